// File: rtl/axi4_master_wr_addr_issue.sv
// axi4_master_wr_addr_issue
// Master-side AXI write-address (AW) channel driver.
//   - Accepts write-burst requests, checks their legality and drops illegal ones
//     (req_err_o pulses one cycle after the accept).
//   - Buffers legal requests in a small FIFO.
//   - Issues them on AW from a registered payload.
//   - Limits issued-but-uncompleted writes by watching the B channel.
//
// Ports
//   axi_clk_i, axi_rstn_i        clock (rising edge); asynchronous active-low reset
//   req_valid_i / req_ready_o    request handshake (ready = FIFO not full)
//   req_id_i .. req_prot_i       request payload (id, addr, len, size, burst, lock, cache, prot)
//   req_err_o                    one-cycle pulse: accepted request was illegal and dropped
//   axi_aw*_o                    registered AW payload
//   axi_awvalid_o / axi_awready_i  AW handshake
//   axi_bvalid_i, axi_bready_i   B channel completion monitor
//   outstanding_o                issued writes still awaiting their B response
//   fsm_state_o                  debug view of the issue FSM (0 IDLE, 1 ISSUE)
//
// Handshake rule for every channel here: a transfer happens on a rising edge
// where valid and ready are both high. A raised valid is never withdrawn, and its
// payload is never changed, until that transfer happens. Valid never depends
// combinationally on ready.
module axi4_master_wr_addr_issue #(
  parameter int AXI_DW          = 32,
  parameter int AXI_AW          = 32,
  parameter int AXI_IW          = 4,
  parameter int AXI_SW          = AXI_DW >> 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              axi_clk_i,
  input  logic              axi_rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AXI_IW-1:0] req_id_i,
  input  logic [AXI_AW-1:0] req_addr_i,
  input  logic [3:0]        req_len_i,
  input  logic [2:0]        req_size_i,
  input  logic [1:0]        req_burst_i,
  input  logic [1:0]        req_lock_i,
  input  logic [3:0]        req_cache_i,
  input  logic [2:0]        req_prot_i,
  output logic              req_err_o,
  output logic [AXI_IW-1:0] axi_awid_o,
  output logic [AXI_AW-1:0] axi_awaddr_o,
  output logic [3:0]        axi_awlen_o,
  output logic [2:0]        axi_awsize_o,
  output logic [1:0]        axi_awburst_o,
  output logic [1:0]        axi_awlock_o,
  output logic [3:0]        axi_awcache_o,
  output logic [2:0]        axi_awprot_o,
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  input  logic              axi_bvalid_i,
  input  logic              axi_bready_i,
  output logic [7:0]        outstanding_o,
  output logic [0:0]        fsm_state_o
);

  localparam int PW    = AXI_IW + AXI_AW + 4 + 3 + 2 + 2 + 4 + 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0]       SIZE_MAX  = 3'($clog2(AXI_SW));
  localparam logic [7:0]       MAX_OUT   = 8'(MAX_OUTSTANDING);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [AXI_AW:0]  ONE_EXT   = (AXI_AW + 1)'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  // ---------------------------------------------------------------------------
  // Legality check. The INCR end address is computed one bit wider than the
  // address, so a wrap past the top of the address space shows up as a
  // page-number mismatch as well.
  // ---------------------------------------------------------------------------
  logic [AXI_AW:0] len_ext;
  logic [AXI_AW:0] span;
  logic [AXI_AW:0] end_addr;
  logic [7:0]      align_mask;
  logic            page_cross;
  logic            wrap_len_ok;
  logic            wrap_aligned;
  logic            req_legal;

  always_comb begin
    len_ext      = '0;
    len_ext[3:0] = req_len_i;
    span         = (len_ext + ONE_EXT) << req_size_i;
    end_addr     = {1'b0, req_addr_i} + span - ONE_EXT;
    page_cross   = (end_addr[AXI_AW:12] != {1'b0, req_addr_i[AXI_AW-1:12]});
    wrap_len_ok  = (req_len_i == 4'd1) || (req_len_i == 4'd3) ||
                   (req_len_i == 4'd7) || (req_len_i == 4'd15);
    align_mask   = (8'd1 << req_size_i) - 8'd1;
    wrap_aligned = ((req_addr_i[7:0] & align_mask) == 8'd0);
    req_legal    = 1'b1;
    if (req_burst_i == 2'd3 || req_size_i > SIZE_MAX) begin
      req_legal = 1'b0;
    end else if (req_burst_i == 2'd2 && (!wrap_len_ok || !wrap_aligned)) begin
      req_legal = 1'b0;
    end else if (req_burst_i == 2'd1 && page_cross) begin
      req_legal = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PW-1:0]    req_pl;
  logic [PW-1:0]    head;
  logic             fifo_empty;
  logic             accept;
  logic             push;
  logic             load;

  assign req_pl      = {req_id_i, req_addr_i, req_len_i, req_size_i,
                        req_burst_i, req_lock_i, req_cache_i, req_prot_i};
  assign req_ready_o = (count != CNT_DEPTH);
  assign fifo_empty  = (count == '0);
  assign accept      = req_valid_i & req_ready_o;
  assign push        = accept & req_legal;
  assign head        = mem[rd_ptr];

  always_ff @(posedge axi_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= req_pl;
    end
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_err_o <= 1'b0;
    end else begin
      req_err_o <= accept & ~req_legal;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, load})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding counter. The credit check uses the next value, so a B
  // completion this cycle frees a slot for a load at this very edge.
  // ---------------------------------------------------------------------------
  logic       aw_hs;
  logic       b_done;
  logic [7:0] out_next;

  assign aw_hs  = axi_awvalid_o & axi_awready_i;
  assign b_done = axi_bvalid_i & axi_bready_i;

  always_comb begin
    out_next = outstanding_o;
    if (aw_hs && !b_done) begin
      out_next = outstanding_o + 8'd1;
    end else if (!aw_hs && b_done && outstanding_o != 8'd0) begin
      out_next = outstanding_o - 8'd1;
    end
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      outstanding_o <= 8'd0;
    end else begin
      outstanding_o <= out_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM and AW payload register
  // ---------------------------------------------------------------------------
  logic [0:0] state;

  assign fsm_state_o = state;
  // A new head may be loaded whenever the AW register is free now or is being
  // emptied by a handshake this cycle.
  assign load = !fifo_empty && (out_next < MAX_OUT) && (state == IDLE || aw_hs);

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state         <= IDLE;
      axi_awvalid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state         <= ISSUE;
            axi_awvalid_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (aw_hs && !load) begin
            state         <= IDLE;
            axi_awvalid_o <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          axi_awvalid_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      axi_awid_o    <= '0;
      axi_awaddr_o  <= '0;
      axi_awlen_o   <= '0;
      axi_awsize_o  <= '0;
      axi_awburst_o <= '0;
      axi_awlock_o  <= '0;
      axi_awcache_o <= '0;
      axi_awprot_o  <= '0;
    end else if (load) begin
      {axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awsize_o,
       axi_awburst_o, axi_awlock_o, axi_awcache_o, axi_awprot_o} <= head;
    end
  end

endmodule

// File: tb/tb_axi4_master_wr_addr_issue.sv
// Bench for axi4_master_wr_addr_issue (FIFO_DEPTH 4, MAX_OUTSTANDING 2, 32-bit data).
// A transaction-level reference model predicts every output after each edge.
module tb_axi4_master_wr_addr_issue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } pl_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_id = '0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic [1:0]  req_burst = '0;
  logic [1:0]  req_lock = '0;
  logic [3:0]  req_cache = '0;
  logic [2:0]  req_prot = '0;
  logic        req_err;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic        bvalid = 1'b0;
  logic        bready = 1'b0;
  logic [7:0]  outstanding;
  logic [0:0]  fsm_state;

  axi4_master_wr_addr_issue #(
    .AXI_DW(32), .AXI_AW(32), .AXI_IW(4), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .axi_clk_i(clk), .axi_rstn_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_id_i(req_id), .req_addr_i(req_addr), .req_len_i(req_len),
    .req_size_i(req_size), .req_burst_i(req_burst), .req_lock_i(req_lock),
    .req_cache_i(req_cache), .req_prot_i(req_prot), .req_err_o(req_err),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen),
    .axi_awsize_o(awsize), .axi_awburst_o(awburst), .axi_awlock_o(awlock),
    .axi_awcache_o(awcache), .axi_awprot_o(awprot),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_bvalid_i(bvalid), .axi_bready_i(bready),
    .outstanding_o(outstanding), .fsm_state_o(fsm_state)
  );

  // scoreboard / reference model state
  logic [$bits(pl_t)-1:0] exp_q[$];
  logic [$bits(pl_t)-1:0] exp_cur;
  bit  exp_vld;
  bit  exp_err;
  bit  exp_acc;
  int  exp_out;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Burst legality for a 4-byte data bus, from plain address arithmetic.
  function automatic bit legal_f(input pl_t p);
    longint unsigned bytes;
    longint unsigned last;
    if (p.burst == 2'd3 || p.size > 3'd2) return 1'b0;
    if (p.burst == 2'd2)
      return (p.len == 4'd1 || p.len == 4'd3 || p.len == 4'd7 || p.len == 4'd15) &&
             ((longint'(p.addr) % (longint'(1) << p.size)) == 0);
    if (p.burst == 2'd1) begin
      bytes = (longint'(p.len) + 1) * (longint'(1) << p.size);
      last  = longint'(p.addr) + bytes - 1;
      return (last / 4096) == (longint'(p.addr) / 4096);
    end
    return 1'b1;
  endfunction

  function automatic pl_t cur_req();
    return '{req_id, req_addr, req_len, req_size, req_burst, req_lock, req_cache, req_prot};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_cur = '0;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    exp_acc = 1'b0;
    exp_out = 0;
  endtask

  // One clock edge of the reference model, using the inputs as they stand.
  task automatic model_edge();
    bit hs, b, ld, lg;
    int out_n;
    pl_t p;
    p     = cur_req();
    lg    = legal_f(p);
    exp_acc = req_valid && (exp_q.size() < DEPTH);
    hs    = exp_vld && awready;
    b     = bvalid && bready;
    out_n = exp_out;
    if (hs && !b) out_n = exp_out + 1;
    else if (!hs && b && exp_out > 0) out_n = exp_out - 1;
    ld = (!exp_vld || hs) && (exp_q.size() > 0) && (out_n < MAXO);
    if (ld) begin
      exp_cur = exp_q.pop_front();
      exp_vld = 1'b1;
    end else if (hs) begin
      exp_vld = 1'b0;
    end
    if (exp_acc && lg) exp_q.push_back(p);
    exp_err = exp_acc && !lg;
    exp_out = out_n;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    chk("awvalid", 64'(awvalid), 64'(exp_vld));
    chk("req_ready", 64'(req_ready), 64'(exp_q.size() < DEPTH));
    chk("req_err", 64'(req_err), 64'(exp_err));
    chk("outstanding", 64'(outstanding), 64'(exp_out));
    if (exp_vld)
      chk("aw_payload", 64'({awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot}),
          64'(exp_cur));
  endtask

  task automatic drive_req(input pl_t p, input bit v);
    {req_id, req_addr, req_len, req_size, req_burst, req_lock, req_cache, req_prot} = p;
    req_valid = v;
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send(input pl_t p);
    int n;
    n = 0;
    drive_req(p, 1'b1);
    do begin
      cycle();
      n++;
    end while (!exp_acc && n < 16);
    chk("send_accept", 64'(exp_acc), 64'd1);
    req_valid = 1'b0;
  endtask

  function automatic pl_t rnd_legal();
    pl_t p;
    logic [31:0] a;
    a = $urandom;
    p.id    = 4'($urandom_range(0, 15));
    p.addr  = {a[31:12], 12'h000};
    p.len   = 4'($urandom_range(0, 15));
    p.size  = 3'($urandom_range(0, 2));
    p.burst = 2'd1;
    p.lock  = 2'($urandom_range(0, 3));
    p.cache = 4'($urandom_range(0, 15));
    p.prot  = 3'($urandom_range(0, 7));
    return p;
  endfunction

  function automatic pl_t rnd_any();
    pl_t p;
    logic [31:0] a;
    int r;
    p = rnd_legal();
    a = $urandom;
    r = $urandom_range(0, 3);
    if (r == 0) a[11:0] = 12'hFC0 | 12'($urandom_range(0, 63));
    if (r == 1) a = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
    p.addr  = a;
    p.size  = 3'($urandom_range(0, 3));
    p.burst = 2'($urandom_range(0, 3));
    return p;
  endfunction

  initial begin
    pl_t p;
    // reset
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_req_err", 64'(req_err), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);

    // single INCR burst
    awready = 1'b1;
    p = rnd_legal();
    p.addr = 32'h1000; p.len = 4'd3; p.size = 3'd2;
    drive_req(p, 1'b1);
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("t1_awvalid_after_e1", 64'(awvalid), 64'd1);
    chk("t1_awaddr", 64'(awaddr), 64'h1000);
    cycle();
    chk("t1_outstanding", 64'(outstanding), 64'd1);
    bvalid = 1'b1; bready = 1'b1;
    cycle();
    bvalid = 1'b0; bready = 1'b0;
    chk("t1_outstanding_done", 64'(outstanding), 64'd0);
    cycle();

    // illegal requests
    p = rnd_legal(); p.addr = 32'hFF8; p.len = 4'd3; p.size = 3'd2;
    send(p);
    chk("t3_cross_err", 64'(req_err), 64'd1);
    p = rnd_legal(); p.burst = 2'd2; p.len = 4'd2; p.size = 3'd2;
    send(p);
    chk("t3_wrap_err", 64'(req_err), 64'd1);
    p = rnd_legal(); p.burst = 2'd3;
    send(p);
    chk("t3_burst3_err", 64'(req_err), 64'd1);
    repeat (3) cycle();
    chk("t3_no_aw", 64'(awvalid), 64'd0);

    // backpressure with B held (also spurious B at zero)
    awready = 1'b0; bvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 5; i++) send(rnd_legal());
    chk("t2_fifo_full", 64'(req_ready), 64'd0);
    repeat (5) cycle();
    awready = 1'b1;
    repeat (8) cycle();
    chk("t2_outstanding_zero", 64'(outstanding), 64'd0);
    bvalid = 1'b0; bready = 1'b0;

    // credit limit
    for (int i = 0; i < 4; i++) send(rnd_legal());
    repeat (4) cycle();
    chk("t4_credit_cap", 64'(outstanding), 64'd2);
    chk("t4_blocked", 64'(awvalid), 64'd0);
    bvalid = 1'b1; bready = 1'b1;
    cycle();
    bvalid = 1'b0; bready = 1'b0;
    chk("t4_issue_after_b", 64'(awvalid), 64'd1);
    repeat (2) cycle();
    bvalid = 1'b1; bready = 1'b1;
    repeat (8) cycle();
    bvalid = 1'b0; bready = 1'b0;

    // simultaneous AW handshake and B at outstanding 1
    send(rnd_legal());
    repeat (2) cycle();
    chk("t5_one", 64'(outstanding), 64'd1);
    awready = 1'b0;
    send(rnd_legal());
    cycle();
    awready = 1'b1; bvalid = 1'b1; bready = 1'b1;
    cycle();
    awready = 1'b0; bvalid = 1'b0; bready = 1'b0;
    chk("t5_hs_and_b", 64'(outstanding), 64'd1);
    bvalid = 1'b1; bready = 1'b1;
    repeat (3) cycle();
    chk("t5_spurious_b", 64'(outstanding), 64'd0);
    bvalid = 1'b0; bready = 1'b0;

    // reset while awvalid is held against backpressure
    send(rnd_legal());
    send(rnd_legal());
    cycle();
    chk("t6_pre_awvalid", 64'(awvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_awvalid", 64'(awvalid), 64'd0);
    model_reset();
    cycle();
    #3 rst_n = 1'b1;
    cycle();
    chk("t6_ready", 64'(req_ready), 64'd1);
    chk("t6_outstanding", 64'(outstanding), 64'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!req_valid || exp_acc) drive_req(rnd_any(), $urandom_range(0, 2) != 0);
      awready = $urandom_range(0, 3) != 0;
      bvalid  = $urandom_range(0, 2) == 0;
      bready  = $urandom_range(0, 3) != 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
